// File: rtl/fifo_types.sv
// Shared types for the fifo write-side arbiter.
package fifo_types;

    localparam int unsigned WORD_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request after the last winner.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   next_o
);

    int unsigned idx;

    // Walk last+1, last+2, ... (mod NUM_REQ); the first hit wins.
    always_comb begin
        found_o = 1'b0;
        next_o  = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_i) + k) % NUM_REQ;
            if (!found_o && req_i[IDX_W'(idx)]) begin
                found_o = 1'b1;
                next_o  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers,
// with bursts of up to BURST_LEN beats per grant.
module fifo_wr_arbiter
    import fifo_types::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned BURST_LEN = 4,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  word_t              req_data_i [NUM_REQ],
    output logic [NUM_REQ-1:0] req_rdy_o,
    output logic               fifo_valid_o,
    output word_t              fifo_data_o,
    input  logic               fifo_rdy_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   owner_o,
    output logic               busy_o
);

    localparam int unsigned     CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0] beat_q,  beat_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i   (req_valid_i),
        .last_i  (last_q),
        .found_o (pick_found),
        .next_o  (pick_idx)
    );

    // State and arbitration bookkeeping; producer 0 goes first after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic and the owner's pass-through onto the fifo port.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        beat_d       = beat_q;
        req_rdy_o    = '0;
        fifo_valid_o = 1'b0;
        fifo_data_o  = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    beat_d  = '0;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                fifo_valid_o       = req_valid_i[owner_q];
                fifo_data_o        = req_data_i[owner_q];
                req_rdy_o[owner_q] = fifo_rdy_i;
                if (!req_valid_i[owner_q]) begin
                    // Producer has nothing more to send.
                    state_d = ARB_IDLE;
                    last_d  = owner_q;
                end else if (fifo_rdy_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ARB_IDLE;
                        last_d  = owner_q;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Status outputs derived straight from the registered owner/state.
    always_comb begin
        busy_o  = (state_q == ARB_GRANT);
        owner_o = owner_q;
        grant_o = '0;
        if (busy_o) grant_o[owner_q] = 1'b1;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: per-producer scoreboard plus round-robin grant rules.
module tb_fifo_wr_arbiter;
    import fifo_types::*;

    localparam int N = 4;
    localparam int B = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid;
    word_t        req_data [N];
    logic [N-1:0] req_rdy;
    logic         fifo_valid;
    word_t        fifo_data;
    logic         fifo_rdy;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .BURST_LEN(B)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_rdy_o    (req_rdy),
        .fifo_valid_o (fifo_valid),
        .fifo_data_o  (fifo_data),
        .fifo_rdy_i   (fifo_rdy),
        .grant_o      (grant),
        .owner_o      (owner),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    word_t        exp_q    [N][$];
    word_t        script_q [N][$];
    logic [N-1:0] pending;
    logic [N-1:0] hs_last;
    int           rate [N];
    int           rdy_rate  = 100;
    int           rdy_stall = 0;

    // monitor state
    logic [N-1:0] prev_grant, prev_valid, hs;
    bit           prev_rst;
    int           last_m, cur_owner, cur_beats, g, e, hi;
    int           beats_per [N];
    int           burst_cnt, last_burst_owner, last_burst_len;
    int           grant_log[$], grant_cyc_log[$], beat_cyc_log[$];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // First valid producer after 'last', wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Producer drivers: hold each word until accepted, then maybe offer the next.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_last[i]) pending[i] = 1'b0;
                if (!pending[i]) begin
                    if (script_q[i].size() > 0) begin
                        req_data[i] = script_q[i].pop_front();
                        pending[i]  = 1'b1;
                        exp_q[i].push_back(req_data[i]);
                    end else if (rate[i] > 0 && int'($urandom_range(99)) < rate[i]) begin
                        req_data[i] = word_t'($urandom);
                        pending[i]  = 1'b1;
                        exp_q[i].push_back(req_data[i]);
                    end
                end
                req_valid[i] = pending[i];
            end
            if (rdy_stall > 0) begin
                fifo_rdy  = 1'b0;
                rdy_stall = rdy_stall - 1;
            end else begin
                fifo_rdy = (int'($urandom_range(99)) < rdy_rate);
            end
        end
    end

    // Monitor: sampled mid-cycle, compares against scoreboard and grant rules.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk(grant == 0 && !fifo_valid && req_rdy == 0 && !busy && owner == 0,
                    "reset_outputs", 32'({grant, req_rdy, fifo_valid, busy}), 0);
                prev_grant = '0; prev_rst = 1'b1; last_m = N - 1; cur_beats = 0;
                hs_last = '0; prev_valid = req_valid;
            end else begin
                hs = req_valid & req_rdy;
                if (grant == 0) begin
                    chk(!fifo_valid && req_rdy == 0 && !busy && fifo_data == 0,
                        "idle_outputs", 32'({fifo_data, req_rdy, fifo_valid, busy}), 0);
                    if (prev_grant != 0) begin
                        chk(cur_beats == B || !prev_valid[cur_owner], "release_reason", 32'(cur_beats), B);
                        last_m = cur_owner;
                        burst_cnt++;
                        last_burst_owner = cur_owner;
                        last_burst_len   = cur_beats;
                    end else if (!prev_rst) begin
                        chk(prev_valid == 0, "grant_latency", 32'(prev_valid), 0);
                    end
                end else begin
                    chk($onehot(grant), "grant_onehot", 32'(grant), 0);
                    g = oh2idx(grant);
                    if (prev_grant == 0) begin
                        e = prev_rst ? -1 : pick(prev_valid, last_m);
                        chk(g == e, "grant_rr", g, e);
                        cur_owner = g; cur_beats = 0;
                        grant_log.push_back(g);
                        grant_cyc_log.push_back(cyc);
                    end else begin
                        chk(grant == prev_grant, "grant_held", 32'(grant), 32'(prev_grant));
                        chk(cur_beats < B && prev_valid[cur_owner], "missed_release", 32'(cur_beats), B);
                    end
                    chk(int'(owner) == g && busy && fifo_valid == req_valid[g] &&
                        fifo_data == req_data[g] && req_rdy == (N'(fifo_rdy) << g),
                        "grant_outputs", 32'({owner, busy, fifo_valid, req_rdy}), 32'(g));
                end
                if (fifo_valid && fifo_rdy) begin
                    chk($onehot(hs) && hs == grant, "beat_handshake", 32'(hs), 32'(grant));
                    hi = oh2idx(hs);
                    if (hi >= 0) begin
                        if (exp_q[hi].size() == 0) begin
                            chk(1'b0, "unexpected_word", 32'(fifo_data), 0);
                        end else begin
                            chk(fifo_data == exp_q[hi][0], "word_order", 32'(fifo_data), 32'(exp_q[hi][0]));
                            void'(exp_q[hi].pop_front());
                        end
                        beats_per[hi]++;
                    end
                    beat_cyc_log.push_back(cyc);
                    cur_beats++;
                end else begin
                    chk(hs == 0, "no_stray_handshake", 32'(hs), 0);
                end
                hs_last = hs; prev_grant = grant; prev_valid = req_valid; prev_rst = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = (grant == 0);
            for (int i = 0; i < N; i++)
                if (exp_q[i].size() != 0 || script_q[i].size() != 0) done = 0;
        end
        chk(done, "wait_idle_timeout", 32'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [N-1:0] want, input int beats, input int budget);
        bit hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            hit = (grant == want) && (cur_beats >= beats);
        end
        chk(hit, "wait_grant_timeout", 32'(grant), 32'(want));
    endtask

    initial begin
        int g0, cnt, bc;
        reset = 1'b1; req_valid = '0; fifo_rdy = 1'b1; pending = '0; hs_last = '0;
        for (int i = 0; i < N; i++) begin req_data[i] = '0; rate[i] = 0; beats_per[i] = 0; end
        burst_cnt = 0; last_m = N - 1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // Idle: nothing requested, nothing granted.
        repeat (10) @(posedge clk);
        chk(grant_log.size() == 0, "idle_no_grant", grant_log.size(), 0);

        // Lone producer 1, two words back to back.
        script_q[1].push_back(8'hA5);
        script_q[1].push_back(8'h5A);
        wait_idle(100);
        chk(beats_per[1] == 2, "single_beats", beats_per[1], 2);
        chk(beat_cyc_log.size() == 2 && beat_cyc_log[1] - beat_cyc_log[0] == 1,
            "single_consecutive", beat_cyc_log.size(), 2);
        chk(grant_log.size() == 1 && grant_log[0] == 1, "single_owner", grant_log.size(), 1);

        // Async reset while producer 2 is mid-burst.
        for (int i = 0; i < N; i++) rate[i] = 100;
        wait_grant(4'b0100, 1, 100);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk(grant == 0 && !fifo_valid && req_rdy == 0, "async_reset",
               32'({grant, fifo_valid, req_rdy}), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        grant_log.delete(); grant_cyc_log.delete(); beat_cyc_log.delete();

        // All producers streaming: 0,1,2,3,0 with 16 beats in 20 cycles.
        repeat (26) @(posedge clk);
        chk(grant_log.size() >= 5, "stream_grants", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            for (int k = 0; k < 5; k++)
                chk(grant_log[k] == (k % N), "stream_order", grant_log[k], k % N);
            g0 = grant_cyc_log[0];
            cnt = 0;
            foreach (beat_cyc_log[k])
                if (beat_cyc_log[k] >= g0 && beat_cyc_log[k] < g0 + 20) cnt++;
            chk(cnt == 16, "stream_throughput", cnt, 16);
        end

        // Backpressure mid-burst on owner 0.
        wait_grant(4'b0001, 2, 100);
        bc = burst_cnt;
        rdy_stall = 3;
        for (int c = 0; c < 50 && burst_cnt == bc; c++) @(negedge clk);
        chk(last_burst_owner == 0 && last_burst_len == B, "stall_burst_len", last_burst_len, B);

        // last=2 with 2 and 3 requesting: 3 first, then 2.
        for (int i = 0; i < N; i++) rate[i] = 0;
        wait_idle(200);
        script_q[2].push_back(8'h22);
        wait_idle(100);
        script_q[2].push_back(8'h23);
        script_q[3].push_back(8'h33);
        wait_idle(100);
        chk(grant_log.size() >= 2 && grant_log[grant_log.size()-2] == 3, "rr_after_last2_a",
            grant_log[grant_log.size()-2], 3);
        chk(grant_log[grant_log.size()-1] == 2, "rr_after_last2_b", grant_log[grant_log.size()-1], 2);

        // Random traffic with random backpressure and one reset.
        for (int blk = 0; blk < 30; blk++) begin
            for (int i = 0; i < N; i++) rate[i] = int'($urandom_range(100));
            rdy_rate = int'($urandom_range(100, 30));
            repeat (50) @(posedge clk);
            if (blk == 15) begin
                #3 reset = 1'b1;
                @(posedge clk);
                #3 reset = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) rate[i] = 0;
        rdy_rate = 100;
        wait_idle(1000);
        for (int i = 0; i < N; i++)
            chk(exp_q[i].size() == 0, "words_lost", exp_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1);
    end

endmodule
